// File: rtl/ahblsram_sram_ctrl_pkg.sv
// Shared definitions for the AHB-Lite SRAM controller.
//   state_t      : controller state encoding
//   SZ_*         : AHB HSIZE codes understood by the byte-enable decode
//   RD_LAT_MIN/MAX : supported memory read latency range
package ahblsram_sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR      = 3'd1,
    ST_RD      = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RD_ACK  = 3'd4
  } state_t;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;

  // Width of the read-wait down-counter; covers RD_LAT_MAX-1.
  localparam int CNT_W = 2;

endpackage

// File: rtl/ahblsram_be_decode.sv
// Byte-enable decode for one SRAM access.
//   size     in  3 : latched AHB HSIZE
//   addr_lo  in  2 : latched byte address bits [1:0]
//   is_write in  1 : 1 = write access, 0 = read access
//   be       out 4 : byte enables (reads always enable all lanes)
module ahblsram_be_decode
  import ahblsram_sram_ctrl_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  input  logic       is_write,
  output logic [3:0] be
);

  always_comb begin
    be = 4'b1111;
    if (is_write) begin
      case (size)
        SZ_BYTE: be = 4'b0001 << addr_lo;
        // addr_lo[0] is deliberately ignored for halfwords
        SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
        default: be = 4'b1111;
      endcase
    end
  end

endmodule

// File: rtl/ahblsram_sram_ctrl.sv
// SRAM access sequencer behind an AHB-Lite interface stage.
// Accepts single-cycle requests while idle, issues one write or read strobe
// to the memory and returns a single-cycle ack.
//
// state      | meaning
// -----------+-------------------------------------------------
// ST_IDLE    | waiting for ahbsram_req
// ST_WR      | mem_wen and ack asserted, write data forwarded
// ST_RD      | mem_ren asserted for one cycle
// ST_RD_WAIT | counting down remaining memory read latency
// ST_RD_ACK  | read data registered, ack asserted
//
// Ports:
//   HCLK, HRESETN                    clock, async active-low reset
//   ahbsram_req/write/size/addr_mem  request from AHB stage
//   ahbsram_wdata                    write data (cycle after req)
//   sramahb_ack, sramahb_rdata       completion pulse, held read data
//   BUSY                             high whenever not idle
//   mem_addr/wen/ren/be/wdata/rdata  SRAM port
module ahblsram_sram_ctrl
  import ahblsram_sram_ctrl_pkg::*;
#(
  parameter int MEM_AWIDTH = 19,
  parameter int RD_LATENCY = 1
) (
  input  logic                  HCLK,
  input  logic                  HRESETN,
  input  logic                  ahbsram_req,
  input  logic                  ahbsram_write,
  input  logic [31:0]           ahbsram_wdata,
  input  logic [2:0]            ahbsram_size,
  input  logic [MEM_AWIDTH-1:0] ahbsram_addr_mem,
  output logic                  sramahb_ack,
  output logic [31:0]           sramahb_rdata,
  output logic                  BUSY,
  output logic [MEM_AWIDTH-3:0] mem_addr,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [3:0]            mem_be,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  // Out-of-range latencies are clamped to the supported range.
  localparam int RD_LAT = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                          (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RD_LAT - 1);

  state_t                  state;
  logic                    cmd_write;
  logic [2:0]              cmd_size;
  logic [MEM_AWIDTH-1:0]   cmd_addr;
  logic [CNT_W-1:0]        wait_cnt;
  logic [3:0]              be_dec;

  ahblsram_be_decode u_be_decode (
    .size     (cmd_size),
    .addr_lo  (cmd_addr[1:0]),
    .is_write (cmd_write),
    .be       (be_dec)
  );

  assign mem_addr  = cmd_addr[MEM_AWIDTH-1:2];
  assign mem_wdata = ahbsram_wdata;
  assign mem_be    = (mem_wen || mem_ren) ? be_dec : 4'b0000;

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state         <= ST_IDLE;
      cmd_write     <= 1'b0;
      cmd_size      <= 3'b000;
      cmd_addr      <= '0;
      wait_cnt      <= '0;
      sramahb_ack   <= 1'b0;
      sramahb_rdata <= 32'h0;
      BUSY          <= 1'b0;
      mem_wen       <= 1'b0;
      mem_ren       <= 1'b0;
    end else begin
      sramahb_ack <= 1'b0;
      mem_wen     <= 1'b0;
      mem_ren     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ahbsram_req) begin
            cmd_write <= ahbsram_write;
            cmd_size  <= ahbsram_size;
            cmd_addr  <= ahbsram_addr_mem;
            BUSY      <= 1'b1;
            if (ahbsram_write) begin
              state       <= ST_WR;
              mem_wen     <= 1'b1;
              sramahb_ack <= 1'b1;
            end else begin
              state   <= ST_RD;
              mem_ren <= 1'b1;
            end
          end
        end
        ST_WR: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        ST_RD: begin
          if (RD_LAT == 1) begin
            sramahb_rdata <= mem_rdata;
            sramahb_ack   <= 1'b1;
            state         <= ST_RD_ACK;
          end else begin
            wait_cnt <= WAIT_LOAD;
            state    <= ST_RD_WAIT;
          end
        end
        ST_RD_WAIT: begin
          // Terminal count at 1: the last wait cycle samples the data.
          if (wait_cnt <= CNT_W'(1)) begin
            wait_cnt      <= '0;
            sramahb_rdata <= mem_rdata;
            sramahb_ack   <= 1'b1;
            state         <= ST_RD_ACK;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        ST_RD_ACK: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahblsram_sram_ctrl.sv
module tb_ahblsram_sram_ctrl;

  logic        HCLK;
  logic        HRESETN;
  logic        req;
  logic        write;
  logic [31:0] wdata;
  logic [2:0]  size;
  logic [18:0] addr;
  logic [31:0] mem_rdata;

  logic        ack1, busy1, wen1, ren1;
  logic [31:0] rdata1, wd1;
  logic [16:0] maddr1;
  logic [3:0]  be1;
  logic        ack2, busy2, wen2, ren2;
  logic [31:0] rdata2, wd2;
  logic [16:0] maddr2;
  logic [3:0]  be2;

  ahblsram_sram_ctrl #(.MEM_AWIDTH(19), .RD_LATENCY(1)) dut1 (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .ahbsram_req(req), .ahbsram_write(write), .ahbsram_wdata(wdata),
    .ahbsram_size(size), .ahbsram_addr_mem(addr),
    .sramahb_ack(ack1), .sramahb_rdata(rdata1), .BUSY(busy1),
    .mem_addr(maddr1), .mem_wen(wen1), .mem_ren(ren1), .mem_be(be1),
    .mem_wdata(wd1), .mem_rdata(mem_rdata)
  );

  ahblsram_sram_ctrl #(.MEM_AWIDTH(19), .RD_LATENCY(2)) dut2 (
    .HCLK(HCLK), .HRESETN(HRESETN),
    .ahbsram_req(req), .ahbsram_write(write), .ahbsram_wdata(wdata),
    .ahbsram_size(size), .ahbsram_addr_mem(addr),
    .sramahb_ack(ack2), .sramahb_rdata(rdata2), .BUSY(busy2),
    .mem_addr(maddr2), .mem_wen(wen2), .mem_ren(ren2), .mem_be(be2),
    .mem_wdata(wd2), .mem_rdata(mem_rdata)
  );

  typedef struct {
    int          cyc;
    bit          wr;
    logic [16:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   ren_cnt1 = 0, ren_cnt2 = 0;
  int   exp_ren = 0;

  initial begin
    HCLK = 0;
    forever #5 HCLK = ~HCLK;
  end

  always @(posedge HCLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id, input logic ack, input logic wen, input logic ren,
                     input logic busy, input logic [16:0] ma, input logic [3:0] be,
                     input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    bit   have;
    string p;
    p = (id == 1) ? "dut1" : "dut2";
    if (!wen && !ren) check({p, " be_idle"}, {28'h0, be}, 32'h0);
    if (ren) begin
      check({p, " be_read"}, {28'h0, be}, 32'hF);
      if (id == 1) ren_cnt1++; else ren_cnt2++;
    end
    if (wen) check({p, " wen_with_ack"}, {31'h0, ack}, 32'h1);
    if (ack) begin
      have = 0;
      if (id == 1) begin
        if (q1.size() != 0) begin e = q1.pop_front(); have = 1; end
      end else begin
        if (q2.size() != 0) begin e = q2.pop_front(); have = 1; end
      end
      if (!have) begin
        total++;
        bad++;
        $display("FAIL %s unexpected_ack: got ack expected none (cycle %0d)", p, cyc);
      end else begin
        check({p, " ack_cycle"}, cyc, e.cyc);
        check({p, " ack_addr"}, {15'h0, ma}, {15'h0, e.addr});
        check({p, " ack_busy"}, {31'h0, busy}, 32'h1);
        if (e.wr) begin
          check({p, " wr_wen"}, {31'h0, wen}, 32'h1);
          check({p, " wr_be"}, {28'h0, be}, {28'h0, e.be});
          check({p, " wr_wdata"}, wd, e.data);
        end else begin
          check({p, " rd_data"}, rd, e.data);
        end
      end
    end
  endtask

  always @(negedge HCLK) begin
    mon(1, ack1, wen1, ren1, busy1, maddr1, be1, wd1, rdata1);
    mon(2, ack2, wen2, ren2, busy2, maddr2, be2, wd2, rdata2);
  end

  // Issue one request in the current cycle; returns #1 after the sampling edge
  // with the write data presented for the data phase.
  task automatic do_req(input bit wr, input logic [2:0] sz, input logic [18:0] a,
                        input logic [31:0] wd, input logic [3:0] ebe,
                        input logic [31:0] erd, input bit accepted);
    exp_t e;
    req = 1; write = wr; size = sz; addr = a;
    if (accepted) begin
      e.wr = wr; e.addr = a[18:2]; e.be = ebe; e.data = wr ? wd : erd;
      e.cyc = cyc + (wr ? 1 : 2);
      q1.push_back(e);
      e.cyc = cyc + (wr ? 1 : 3);
      q2.push_back(e);
      if (!wr) exp_ren++;
    end
    @(posedge HCLK); #1;
    req = 0;
    wdata = wd;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " ack"},   {ack1, ack2, busy1, busy2, wen1, wen2, ren1, ren2}, 0);
    check({tag, " be"},    {be1, be2}, 0);
    check({tag, " rdata1"}, rdata1, 0);
    check({tag, " rdata2"}, rdata2, 0);
  endtask

  initial begin
    HRESETN = 0; req = 0; write = 0; wdata = 0; size = 0; addr = 0;
    mem_rdata = 32'h0;
    step(3);
    check_zero("reset");
    HRESETN = 1;
    step(1);

    // word write
    do_req(1, 3'b010, 19'h00010, 32'hDEADBEEF, 4'b1111, 0, 1);
    step(1);
    // byte writes on every lane, halfwords, oversize HSIZE
    do_req(1, 3'b000, 19'h00020, 32'h000000A1, 4'b0001, 0, 1); step(1);
    do_req(1, 3'b000, 19'h00021, 32'h0000B200, 4'b0010, 0, 1); step(1);
    do_req(1, 3'b000, 19'h00022, 32'h00C30000, 4'b0100, 0, 1); step(1);
    do_req(1, 3'b000, 19'h00023, 32'hD4000000, 4'b1000, 0, 1); step(1);
    do_req(1, 3'b001, 19'h00032, 32'h55660000, 4'b1100, 0, 1); step(1);
    do_req(1, 3'b001, 19'h00030, 32'h00007788, 4'b0011, 0, 1); step(1);
    do_req(1, 3'b001, 19'h00033, 32'h99AA0000, 4'b1100, 0, 1); step(1);
    do_req(1, 3'b011, 19'h00005, 32'h13572468, 4'b1111, 0, 1); step(1);
    check("idle busy", {busy1, busy2}, 0);

    // read, then confirm the read data is held across a later write
    mem_rdata = 32'hA5A55A5A;
    do_req(0, 3'b010, 19'h00044, 0, 4'b1111, 32'hA5A55A5A, 1);
    step(3);
    mem_rdata = 32'h12345678;
    do_req(1, 3'b010, 19'h00048, 32'h0F0F0F0F, 4'b1111, 0, 1);
    step(1);
    check("hold rdata1", rdata1, 32'hA5A55A5A);
    check("hold rdata2", rdata2, 32'hA5A55A5A);

    // byte-sized read still enables all lanes
    mem_rdata = 32'h0BADF00D;
    do_req(0, 3'b000, 19'h00047, 0, 4'b1111, 32'h0BADF00D, 1);
    step(3);

    // request arriving while busy (RD_ACK / RD_WAIT) is ignored
    mem_rdata = 32'h11112222;
    do_req(0, 3'b010, 19'h00100, 0, 4'b1111, 32'h11112222, 1);
    step(1);
    check("busy while reading", {busy1, busy2}, 2'b11);
    do_req(1, 3'b010, 19'h00200, 32'hFFFFFFFF, 4'b1111, 0, 0);
    step(1);

    // reset in RD aborts the access
    mem_rdata = 32'h77778888;
    do_req(0, 3'b010, 19'h00104, 0, 4'b1111, 32'h77778888, 1);
    #1 HRESETN = 0;
    #1 check_zero("midreset");
    q1.delete();
    q2.delete();
    exp_ren--;
    step(1);
    HRESETN = 1;
    step(4);

    // normal read after reset
    mem_rdata = 32'hCAFEF00D;
    do_req(0, 3'b010, 19'h00200, 0, 4'b1111, 32'hCAFEF00D, 1);
    step(3);

    // INCR4 write burst, one request every other cycle
    do_req(1, 3'b010, 19'h00300, 32'h00000001, 4'b1111, 0, 1); step(1);
    do_req(1, 3'b010, 19'h00304, 32'h00000002, 4'b1111, 0, 1); step(1);
    do_req(1, 3'b010, 19'h00308, 32'h00000003, 4'b1111, 0, 1); step(1);
    do_req(1, 3'b010, 19'h0030C, 32'h00000004, 4'b1111, 0, 1); step(1);

    step(5);
    check("dut1 pending acks", q1.size(), 0);
    check("dut2 pending acks", q2.size(), 0);
    check("dut1 ren count", ren_cnt1, exp_ren);
    check("dut2 ren count", ren_cnt2, exp_ren);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
